// File: rtl/writeback_unit_if.sv
// Bus bundle for writeback_unit: pipeline result, LL result handshake,
// LL issue/scoreboard query and the register file write port.
// Optional bypass read data is present when WB_BYPASS_EN is defined.
interface writeback_unit_if;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic        pipe_is_load;
  logic [2:0]  pipe_funct3;
  logic [1:0]  pipe_addr_lo;
  logic [31:0] pipe_data;

  logic        ll_valid;
  logic        ll_ready;
  logic [4:0]  ll_rd;
  logic [31:0] ll_data;

  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        rs1_busy;
  logic        rs2_busy;

  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] write_data;

`ifdef WB_BYPASS_EN
  logic [31:0] rf_rs1_data;
  logic [31:0] rf_rs2_data;
  logic [31:0] byp_rs1_data;
  logic [31:0] byp_rs2_data;
`endif

  modport slave (
`ifdef WB_BYPASS_EN
    input  rf_rs1_data, rf_rs2_data,
    output byp_rs1_data, byp_rs2_data,
`endif
    input  pipe_valid, pipe_rd, pipe_is_load, pipe_funct3, pipe_addr_lo, pipe_data,
    input  ll_valid, ll_rd, ll_data,
    output ll_ready,
    input  issue_valid, issue_rd, rs1_addr, rs2_addr,
    output rs1_busy, rs2_busy,
    output wb_en, wb_addr, write_data
  );

  modport master (
`ifdef WB_BYPASS_EN
    output rf_rs1_data, rf_rs2_data,
    input  byp_rs1_data, byp_rs2_data,
`endif
    output pipe_valid, pipe_rd, pipe_is_load, pipe_funct3, pipe_addr_lo, pipe_data,
    output ll_valid, ll_rd, ll_data,
    input  ll_ready,
    output issue_valid, issue_rd, rs1_addr, rs2_addr,
    input  rs1_busy, rs2_busy,
    input  wb_en, wb_addr, write_data
  );
endinterface

// File: rtl/writeback_unit.sv
// writeback_unit: final stage driving the integer register file write port.
// Merges in-order pipeline results (with load alignment) and buffered
// long-latency results, and tracks registers with LL results outstanding.
// Optional feature macro: WB_BYPASS_EN (write-first read bypass ports).
module writeback_unit #(
  parameter int unsigned LL_DEPTH = 2
) (
  input logic            clk,
  input logic            rst,
  writeback_unit_if.slave bus
);

  localparam int unsigned PTR_W = (LL_DEPTH > 1) ? $clog2(LL_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ll_entry_t;

  ll_entry_t        fifo_mem [LL_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      pipe_result;

  logic             sel_valid;
  logic             sel_ll;
  logic [4:0]       sel_rd;
  logic [31:0]      sel_data;

  logic             wb_is_ll;
  logic [31:1]      pending;
  logic [31:0]      pend_vec;
  logic [31:0]      pend_next;

  // FIFO status and LL handshake; ready depends only on registered occupancy
  assign fifo_full    = (count == CNT_W'(LL_DEPTH));
  assign fifo_empty   = (count == '0);
  assign bus.ll_ready = !fifo_full;
  assign push         = bus.ll_valid && !fifo_full;
  assign pop          = !bus.pipe_valid && !fifo_empty;

  // Load alignment and extension of the raw memory word
  always_comb begin
    ld_byte     = bus.pipe_data[7:0];
    ld_half     = bus.pipe_addr_lo[1] ? bus.pipe_data[31:16] : bus.pipe_data[15:0];
    pipe_result = bus.pipe_data;
    case (bus.pipe_addr_lo)
      2'd0:    ld_byte = bus.pipe_data[7:0];
      2'd1:    ld_byte = bus.pipe_data[15:8];
      2'd2:    ld_byte = bus.pipe_data[23:16];
      default: ld_byte = bus.pipe_data[31:24];
    endcase
    if (bus.pipe_is_load) begin
      case (bus.pipe_funct3)
        3'b000:  pipe_result = {{24{ld_byte[7]}}, ld_byte};
        3'b100:  pipe_result = {24'd0, ld_byte};
        3'b001:  pipe_result = {{16{ld_half[15]}}, ld_half};
        3'b101:  pipe_result = {16'd0, ld_half};
        default: pipe_result = bus.pipe_data;
      endcase
    end
  end

  // Source selection: pipeline first, then FIFO head
  always_comb begin
    sel_valid = 1'b0;
    sel_ll    = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    if (bus.pipe_valid) begin
      sel_valid = 1'b1;
      sel_rd    = bus.pipe_rd;
      sel_data  = pipe_result;
    end else if (!fifo_empty) begin
      sel_valid = 1'b1;
      sel_ll    = 1'b1;
      sel_rd    = fifo_mem[rd_ptr].rd;
      sel_data  = fifo_mem[rd_ptr].data;
    end
  end

  // FIFO storage, written on an accepted LL transfer
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{rd: bus.ll_rd, data: bus.ll_data};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered write port; rd=0 results are consumed but never written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.wb_en      <= 1'b0;
      bus.wb_addr    <= '0;
      bus.write_data <= '0;
      wb_is_ll       <= 1'b0;
    end else begin
      bus.wb_en <= sel_valid && (sel_rd != 5'd0);
      wb_is_ll  <= sel_ll && (sel_rd != 5'd0);
      if (sel_valid) begin
        bus.wb_addr    <= sel_rd;
        bus.write_data <= sel_data;
      end
    end
  end

  // Scoreboard next state: clear after the LL write cycle, set on issue (set wins)
  assign pend_vec = {pending, 1'b0};
  always_comb begin
    pend_next = pend_vec;
    if (bus.wb_en && wb_is_ll) pend_next[bus.wb_addr] = 1'b0;
    if (bus.issue_valid)       pend_next[bus.issue_rd] = 1'b1;
    pend_next[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= pend_next[31:1];
  end

  // Busy lookup; bit 0 of pend_vec is constant zero
  assign bus.rs1_busy = pend_vec[bus.rs1_addr];
  assign bus.rs2_busy = pend_vec[bus.rs2_addr];

`ifdef WB_BYPASS_EN
  // Write-first read bypass of the value being written this cycle
  assign bus.byp_rs1_data = (bus.wb_en && bus.wb_addr == bus.rs1_addr && bus.rs1_addr != 5'd0)
                            ? bus.write_data : bus.rf_rs1_data;
  assign bus.byp_rs2_data = (bus.wb_en && bus.wb_addr == bus.rs2_addr && bus.rs2_addr != 5'd0)
                            ? bus.write_data : bus.rf_rs2_data;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Testbench for writeback_unit: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based behavioural model.
module tb_writeback_unit;
  localparam int DEPTH = 2;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  writeback_unit_if bus ();

  writeback_unit #(.LL_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ll_t;

  ll_t         mq[$];
  bit          pend[32];
  bit          m_en;
  bit          m_ll;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] align(input bit ld, input logic [2:0] f3,
                                        input logic [1:0] lo, input logic [31:0] d);
    logic [31:0] b;
    logic [31:0] h;
    b = d >> (int'(lo) * 8);
    h = d >> (int'(lo[1]) * 16);
    if (!ld) return d;
    case (f3)
      3'd0:    return {{24{b[7]}}, b[7:0]};
      3'd4:    return {24'd0, b[7:0]};
      3'd1:    return {{16{h[15]}}, h[15:0]};
      3'd5:    return {16'd0, h[15:0]};
      default: return d;
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    foreach (pend[i]) pend[i] = 1'b0;
    m_en = 0; m_ll = 0; m_addr = '0; m_data = '0;
  endtask

  // Compare DUT against model, then advance model by one clock
  task automatic model_step();
    ll_t         e;
    bit          acc;
    bit          nv;
    bit          nll;
    logic [4:0]  nrd;
    logic [31:0] nd;
    if (rst) model_reset();
    chk("wb_en", 32'(bus.wb_en), 32'(m_en));
    if (m_en || rst) begin
      chk("wb_addr", 32'(bus.wb_addr), 32'(m_addr));
      chk("write_data", bus.write_data, m_data);
    end
    chk("ll_ready", 32'(bus.ll_ready), 32'(mq.size() < DEPTH));
    chk("rs1_busy", 32'(bus.rs1_busy), 32'(bus.rs1_addr != 0 && pend[bus.rs1_addr]));
    chk("rs2_busy", 32'(bus.rs2_busy), 32'(bus.rs2_addr != 0 && pend[bus.rs2_addr]));
`ifdef WB_BYPASS_EN
    chk("byp_rs1", bus.byp_rs1_data,
        (m_en && m_addr == bus.rs1_addr && bus.rs1_addr != 0) ? m_data : bus.rf_rs1_data);
    chk("byp_rs2", bus.byp_rs2_data,
        (m_en && m_addr == bus.rs2_addr && bus.rs2_addr != 0) ? m_data : bus.rf_rs2_data);
`endif
    if (rst) return;
    acc = bus.ll_valid && (mq.size() < DEPTH);
    nv = 0; nll = 0; nrd = '0; nd = '0;
    if (bus.pipe_valid) begin
      nv = 1; nrd = bus.pipe_rd;
      nd = align(bus.pipe_is_load, bus.pipe_funct3, bus.pipe_addr_lo, bus.pipe_data);
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      nv = 1; nll = 1; nrd = e.rd; nd = e.data;
    end
    if (m_en && m_ll) pend[m_addr] = 1'b0;
    if (bus.issue_valid && bus.issue_rd != 0) pend[bus.issue_rd] = 1'b1;
    if (acc) begin
      e.rd = bus.ll_rd; e.data = bus.ll_data;
      mq.push_back(e);
    end
    m_en = nv && nrd != 0;
    m_ll = nll && nrd != 0;
    if (nv) begin m_addr = nrd; m_data = nd; end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.pipe_valid = 0; bus.pipe_rd = '0; bus.pipe_is_load = 0;
    bus.pipe_funct3 = '0; bus.pipe_addr_lo = '0; bus.pipe_data = '0;
    bus.ll_valid = 0; bus.ll_rd = '0; bus.ll_data = '0;
    bus.issue_valid = 0; bus.issue_rd = '0;
    bus.rs1_addr = '0; bus.rs2_addr = '0;
`ifdef WB_BYPASS_EN
    bus.rf_rs1_data = '0; bus.rf_rs2_data = '0;
`endif
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] exp);
    bus.pipe_valid = 1; bus.pipe_rd = 5'd4; bus.pipe_is_load = 1;
    bus.pipe_funct3 = f3; bus.pipe_addr_lo = lo; bus.pipe_data = 32'h80F1_7F22;
    cycle();
    idle();
    chk("load_wb_en", 32'(bus.wb_en), 32'd1);
    chk("load_data", bus.write_data, exp);
  endtask

  task automatic ll_write(input logic [4:0] rd, input logic [31:0] d);
    bus.ll_valid = 1; bus.ll_rd = rd; bus.ll_data = d;
    cycle();
    bus.ll_valid = 0;
    cycle();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    model_reset();
    idle();
    rst = 1;
    cycle();
    cycle();
    rst = 0;
    #1;
    chk("reset_wb_en", 32'(bus.wb_en), 32'd0);
    chk("reset_wb_addr", 32'(bus.wb_addr), 32'd0);
    chk("reset_wdata", bus.write_data, 32'd0);
    chk("reset_ready", 32'(bus.ll_ready), 32'd1);
    cycle();

    // load alignment
    do_load(3'b000, 2'd3, 32'hFFFF_FF80);
    do_load(3'b100, 2'd2, 32'h0000_00F1);
    do_load(3'b101, 2'd2, 32'h0000_80F1);
    do_load(3'b001, 2'd0, 32'h0000_7F22);
    do_load(3'b010, 2'd1, 32'h80F1_7F22);
    cycle();

    // priority and buffering
    bus.pipe_valid = 1; bus.pipe_rd = 5'd1; bus.pipe_data = 32'hA5A5_0001;
    bus.ll_valid = 1; bus.ll_rd = 5'd7; bus.ll_data = 32'h11;
    cycle();
    bus.ll_rd = 5'd8; bus.ll_data = 32'h22;
    cycle();
    bus.ll_valid = 0;
    chk("full_ready", 32'(bus.ll_ready), 32'd0);
    cycle();
    cycle();
    bus.pipe_valid = 0;
    cycle();
    chk("ll1_addr", 32'(bus.wb_addr), 32'd7);
    chk("ll1_data", bus.write_data, 32'h11);
    cycle();
    chk("ll2_addr", 32'(bus.wb_addr), 32'd8);
    chk("ll2_data", bus.write_data, 32'h22);
    cycle();
    chk("drained_en", 32'(bus.wb_en), 32'd0);
    chk("drained_ready", 32'(bus.ll_ready), 32'd1);

    // scoreboard set / clear / set-wins
    bus.issue_valid = 1; bus.issue_rd = 5'd9;
    cycle();
    bus.issue_valid = 0; bus.rs2_addr = 5'd9;
    #1;
    chk("sb_busy_set", 32'(bus.rs2_busy), 32'd1);
    ll_write(5'd9, 32'h99);
    chk("sb_wb_x9", 32'(bus.wb_addr), 32'd9);
    chk("sb_busy_wb", 32'(bus.rs2_busy), 32'd1);
    cycle();
    chk("sb_busy_clr", 32'(bus.rs2_busy), 32'd0);
    bus.issue_valid = 1; bus.issue_rd = 5'd9;
    cycle();
    bus.issue_valid = 0;
    ll_write(5'd9, 32'h98);
    bus.issue_valid = 1; bus.issue_rd = 5'd9;
    cycle();
    bus.issue_valid = 0;
    chk("sb_set_wins", 32'(bus.rs2_busy), 32'd1);
    ll_write(5'd9, 32'h97);
    cycle();
    chk("sb_final_clr", 32'(bus.rs2_busy), 32'd0);

    // register 0
    idle();
    bus.pipe_valid = 1; bus.pipe_rd = 5'd0; bus.pipe_data = 32'hDEAD;
    cycle();
    idle();
    chk("x0_pipe_en", 32'(bus.wb_en), 32'd0);
    bus.issue_valid = 1; bus.issue_rd = 5'd0;
    cycle();
    bus.issue_valid = 0;
    #1;
    chk("x0_busy", 32'(bus.rs1_busy), 32'd0);
    ll_write(5'd0, 32'h55);
    chk("x0_ll_en", 32'(bus.wb_en), 32'd0);
    chk("x0_ll_popped", 32'(bus.ll_ready), 32'd1);

`ifdef WB_BYPASS_EN
    // write-first bypass
    bus.pipe_valid = 1; bus.pipe_rd = 5'd3; bus.pipe_data = 32'h1234;
    cycle();
    bus.pipe_valid = 0; bus.rs1_addr = 5'd3; bus.rf_rs1_data = 32'd0;
    #1;
    chk("byp_hit", bus.byp_rs1_data, 32'h1234);
    bus.rs1_addr = 5'd0; bus.rf_rs1_data = 32'hCAFE;
    #1;
    chk("byp_x0", bus.byp_rs1_data, 32'hCAFE);
    cycle();
    idle();
`endif

    // reset mid-stream with buffered LL entries and x5 pending
    bus.issue_valid = 1; bus.issue_rd = 5'd5;
    cycle();
    bus.issue_valid = 0;
    bus.pipe_valid = 1; bus.pipe_rd = 5'd1; bus.pipe_data = 32'h1;
    bus.ll_valid = 1; bus.ll_rd = 5'd5; bus.ll_data = 32'h55;
    cycle();
    bus.ll_rd = 5'd6; bus.ll_data = 32'h66;
    cycle();
    bus.ll_valid = 0; bus.rs1_addr = 5'd5;
    #1;
    chk("pre_rst_busy", 32'(bus.rs1_busy), 32'd1);
    chk("pre_rst_full", 32'(bus.ll_ready), 32'd0);
    rst = 1; bus.pipe_valid = 0;
    #1;
    chk("rst_wb_en", 32'(bus.wb_en), 32'd0);
    cycle();
    rst = 0;
    #1;
    chk("post_rst_ready", 32'(bus.ll_ready), 32'd1);
    chk("post_rst_busy", 32'(bus.rs1_busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("post_rst_no_wb", 32'(bus.wb_en), 32'd0);
    end

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      bus.pipe_valid   = ($urandom_range(0, 2) == 0);
      bus.pipe_rd      = 5'($urandom);
      bus.pipe_is_load = 1'($urandom);
      bus.pipe_funct3  = 3'($urandom);
      bus.pipe_addr_lo = 2'($urandom);
      bus.pipe_data    = $urandom;
      bus.ll_valid     = ($urandom_range(0, 1) == 0);
      bus.ll_rd        = 5'($urandom_range(0, 7));
      bus.ll_data      = $urandom;
      bus.issue_valid  = ($urandom_range(0, 3) == 0);
      bus.issue_rd     = 5'($urandom_range(0, 7));
      bus.rs1_addr     = 5'($urandom_range(0, 7));
      bus.rs2_addr     = 5'($urandom_range(0, 7));
`ifdef WB_BYPASS_EN
      bus.rf_rs1_data  = $urandom;
      bus.rf_rs2_data  = $urandom;
`endif
      rst = (i % 700 == 350);
      cycle();
    end
    rst = 0;
    idle();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
